popcount_dma: RTL and testbench

- Bus initiator that drives the single-port data-memory interface: async read, sync write, word addressed by byte-address bits [31:2].
- On `start`, walks `len` words from `src_addr`, counts the set bits in each word, writes each count to `dst_addr`, and reports a running total.
- Moves the 32-bit bit-counter workload from the RISC-V core into a hardware engine sharing the dmem port. Top-level muxes core/engine onto dmem using `busy`.

---
 rtl/popcount_pkg.sv | 24 ++
 rtl/popcount_step.sv | 17 +
 rtl/popcount_dma.sv | 134 +++++++++++++
 tb/tb_popcount_dma.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/popcount_pkg.sv
// Shared types and constants for the popcount DMA engine.
// The FSM states and the per-word cycle budget live here so the engine and its users agree.
package popcount_pkg;

   localparam int WORD_W       = 32;
   localparam int MEM_WORDS    = 64;
   localparam int STEP_DEFAULT = 4;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      COUNT,
      WRITE,
      DONE
   } state_t;

   function automatic int count_cycles(input int step);
      return WORD_W / step;
   endfunction

   // READ + COUNT cycles + WRITE for one word
   localparam int WORD_CYCLES = 2 + count_cycles(STEP_DEFAULT);

endpackage

// File: rtl/popcount_step.sv
// Combinational population count of one STEP-bit slice.
module popcount_step #(
   parameter int STEP = 4,
   localparam int CNT_W = $clog2(STEP) + 1
) (
   input  logic [STEP-1:0]  bits,
   output logic [CNT_W-1:0] count
);

   always_comb begin
      count = '0;
      for (int k = 0; k < STEP; k++) begin
         count = count + CNT_W'(bits[k]);
      end
   end

endmodule

// File: rtl/popcount_dma.sv
// Bus initiator: reads len words from src, writes each word's set-bit count to dst,
// and accumulates the total; shares the single-port dmem with the core while busy.
module popcount_dma
   import popcount_pkg::*;
#(
   parameter int STEP  = 4,
   parameter int LEN_W = 7,
   parameter int TOT_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [31:0]       src_addr,
   input  logic [31:0]       dst_addr,
   input  logic [LEN_W-1:0]  len,
   output logic [31:0]       mem_a,
   output logic              mem_we,
   output logic [31:0]       mem_wd,
   input  logic [31:0]       mem_rd,
   output logic              busy,
   output logic              done,
   output logic [TOT_W-1:0]  total_bits
);

   localparam int CYC  = count_cycles(STEP);
   localparam int K_W  = (CYC > 1) ? $clog2(CYC) : 1;
   localparam int PC_W = $clog2(STEP) + 1;

   state_t             state_q, state_d;
   logic [31:0]        src_q, src_d;
   logic [31:0]        dst_q, dst_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   i_q, i_d;
   logic [WORD_W-1:0]  shift_q, shift_d;
   logic [5:0]         wc_q, wc_d;
   logic [K_W-1:0]     k_q, k_d;
   logic [TOT_W-1:0]   total_q, total_d;

   logic [PC_W-1:0]    slice_count;
   logic [31:0]        addr_off;
   logic [LEN_W:0]     i_next;

   popcount_step #(.STEP(STEP)) u_step (
      .bits  (shift_q[STEP-1:0]),
      .count (slice_count)
   );

   assign addr_off   = 32'({i_q, 2'b00});
   assign i_next     = {1'b0, i_q} + {{LEN_W{1'b0}}, 1'b1};
   assign total_bits = total_q;

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      len_d   = len_q;
      i_d     = i_q;
      shift_d = shift_q;
      wc_d    = wc_q;
      k_d     = k_q;
      total_d = total_q;
      busy    = (state_q != IDLE);
      done    = 1'b0;
      mem_a   = 32'h0;
      mem_we  = 1'b0;
      mem_wd  = 32'h0;

      case (state_q)
         IDLE: begin
            if (start) begin
               src_d   = src_addr & 32'hFFFF_FFFC;
               dst_d   = dst_addr & 32'hFFFF_FFFC;
               len_d   = len;
               total_d = '0;
               i_d     = '0;
               state_d = (len != '0) ? READ : DONE;
            end
         end
         READ: begin
            mem_a   = src_q + addr_off;
            shift_d = mem_rd;
            wc_d    = '0;
            k_d     = '0;
            state_d = COUNT;
         end
         COUNT: begin
            wc_d    = wc_q + 6'(slice_count);
            shift_d = shift_q >> STEP;
            k_d     = k_q + 1'b1;
            if (k_q == K_W'(CYC - 1)) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            mem_we  = 1'b1;
            mem_a   = dst_q + addr_off;
            mem_wd  = 32'(wc_q);
            total_d = total_q + TOT_W'(wc_q);
            i_d     = i_next[LEN_W-1:0];
            state_d = (i_next < {1'b0, len_q}) ? READ : DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         i_q     <= '0;
         shift_q <= '0;
         wc_q    <= '0;
         k_q     <= '0;
         total_q <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         i_q     <= i_d;
         shift_q <= shift_d;
         wc_q    <= wc_d;
         k_q     <= k_d;
         total_q <= total_d;
      end
   end

endmodule

// File: tb/tb_popcount_dma.sv
// Self-checking bench for popcount_dma: behavioural dmem, write scoreboard, per-scenario tasks.
module tb_popcount_dma;
   import popcount_pkg::*;

   localparam int STEP     = 4;
   localparam int LEN_W    = 7;
   localparam int TOT_W    = 12;
   localparam int PER_WORD = 2 + 32 / STEP;
   localparam int DEPTH    = 4 * MEM_WORDS;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [31:0]       src_addr = '0;
   logic [31:0]       dst_addr = '0;
   logic [LEN_W-1:0]  len = '0;
   logic [31:0]       mem_a;
   logic              mem_we;
   logic [31:0]       mem_wd;
   logic [31:0]       mem_rd;
   logic              busy;
   logic              done;
   logic [TOT_W-1:0]  total_bits;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic [31:0] mem [0:DEPTH-1];
   wr_t         exp_q[$];
   wr_t         obs_q[$];
   int          rel_q[$];
   int          edge_cnt = 0;
   int          s_g = 0;
   int          done_cnt = 0;
   int          wr_cnt = 0;
   int          exp_total = 0;
   int          n_vec = 0;
   int          n_err = 0;

   popcount_dma #(.STEP(STEP), .LEN_W(LEN_W), .TOT_W(TOT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .len        (len),
      .mem_a      (mem_a),
      .mem_we     (mem_we),
      .mem_wd     (mem_wd),
      .mem_rd     (mem_rd),
      .busy       (busy),
      .done       (done),
      .total_bits (total_bits)
   );

   always #5 clk = ~clk;

   assign mem_rd = mem[mem_a[9:2]];

   always @(posedge clk) begin
      edge_cnt = edge_cnt + 1;
      if (mem_we) mem[mem_a[9:2]] = mem_wd;
   end

   always @(negedge clk) begin
      if (done) done_cnt = done_cnt + 1;
      if (mem_we) begin
         obs_q.push_back('{addr: mem_a, data: mem_wd});
         rel_q.push_back(edge_cnt + 1 - s_g);
         wr_cnt = wr_cnt + 1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout edge_cnt=%0d", edge_cnt);
      $fatal(1, "timeout");
   end

   // Builds expected writes from a private memory copy, then issues one start edge.
   task automatic launch(input logic [31:0] s_a, input logic [31:0] d_a, input int n);
      logic [31:0] shadow [0:DEPTH-1];
      logic [31:0] sw, dw, cnt;
      shadow    = mem;
      exp_total = 0;
      exp_q.delete();
      obs_q.delete();
      rel_q.delete();
      for (int j = 0; j < n; j++) begin
         sw  = (s_a & 32'hFFFF_FFFC) + 32'(4 * j);
         dw  = (d_a & 32'hFFFF_FFFC) + 32'(4 * j);
         cnt = 32'($countones(shadow[sw[9:2]]));
         exp_q.push_back('{addr: dw, data: cnt});
         shadow[dw[9:2]] = cnt;
         exp_total += int'(cnt);
      end
      @(negedge clk);
      src_addr = s_a;
      dst_addr = d_a;
      len      = LEN_W'(n);
      start    = 1'b1;
      @(posedge clk);
      #1;
      s_g   = edge_cnt;
      start = 1'b0;
   endtask

   task automatic wait_done(input int n, input string tag);
      int  rel   = 0;
      bit  found = 0;
      wr_t e, o;
      for (int c = 0; c < n * PER_WORD + 20 && !found; c++) begin
         @(negedge clk);
         if (done) begin
            found = 1;
            rel   = edge_cnt - s_g + 1;
         end
      end
      n_vec++;
      if (!found || rel != n * PER_WORD + 1) begin
         n_err++;
         $display("FAIL %s_done_edge got=%0d found=%0d want=%0d", tag, rel, found, n * PER_WORD + 1);
      end
      n_vec++;
      if (int'(total_bits) != exp_total) begin
         n_err++;
         $display("FAIL %s_total got=%0d want=%0d", tag, total_bits, exp_total);
      end
      n_vec++;
      if (obs_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL %s_write_count got=%0d want=%0d", tag, obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_vec++;
         if (o.addr !== e.addr || o.data !== e.data) begin
            n_err++;
            $display("FAIL %s_write got=%h:%h want=%h:%h", tag, o.addr, o.data, e.addr, e.data);
         end
      end
      exp_q.delete();
      obs_q.delete();
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL %s_idle_busy got=%b want=0", tag, busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({busy, done, mem_we} !== 3'b000 || mem_a !== 32'h0 || mem_wd !== 32'h0 || total_bits !== '0) begin
         n_err++;
         $display("FAIL reset_outputs busy=%b done=%b we=%b a=%h wd=%h tot=%0d want all 0",
                  busy, done, mem_we, mem_a, mem_wd, total_bits);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      logic [31:0] want [0:4] = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd1};
      mem[0] = 32'h0000_0000; mem[1] = 32'h0000_0001; mem[2] = 32'h0000_0200;
      mem[3] = 32'h0040_0000; mem[4] = 32'h8000_0000;
      launch(32'h0, 32'h100, 5);
      wait_done(5, "basic");
      for (int j = 0; j < 5; j++) begin
         n_vec++;
         if (mem[64 + j] !== want[j]) begin
            n_err++;
            $display("FAIL basic_mem[%0d] got=%h want=%h", 64 + j, mem[64 + j], want[j]);
         end
      end
      n_vec++;
      if (total_bits !== 12'd4) begin
         n_err++;
         $display("FAIL basic_total_const got=%0d want=4", total_bits);
      end
   endtask

   task automatic test_dense();
      mem[9] = 32'hFFFF_FFFF; mem[10] = 32'h7FFF_FFFF; mem[11] = 32'hFFFF_FFFE;
      launch(32'h24, 32'h80, 3);
      wait_done(3, "dense");
      n_vec++;
      if (mem[32] !== 32'd32 || mem[33] !== 32'd31 || mem[34] !== 32'd31 || total_bits !== 12'd94) begin
         n_err++;
         $display("FAIL dense_result got=%0d,%0d,%0d tot=%0d want=32,31,31 tot=94",
                  mem[32], mem[33], mem[34], total_bits);
      end
      n_vec++;
      if (rel_q.size() != 3 || rel_q[0] != 10 || rel_q[1] != 20 || rel_q[2] != 30) begin
         n_err++;
         $display("FAIL dense_we_edges got=%p want=10,20,30", rel_q);
      end
   endtask

   task automatic test_inplace();
      mem[8] = 32'h9999_9999;
      launch(32'h20, 32'h20, 1);
      wait_done(1, "inplace");
      n_vec++;
      if (mem[8] !== 32'd16 || total_bits !== 12'd16) begin
         n_err++;
         $display("FAIL inplace got=%0d tot=%0d want=16 tot=16", mem[8], total_bits);
      end
   endtask

   task automatic test_len_zero();
      int w0 = wr_cnt;
      launch(32'h0, 32'h100, 0);
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b1 || done !== 1'b1) begin
         n_err++;
         $display("FAIL len0_done got busy=%b done=%b want 1,1", busy, done);
      end
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0 || wr_cnt != w0 || total_bits !== '0) begin
         n_err++;
         $display("FAIL len0_after got busy=%b done=%b writes=%0d tot=%0d want 0,0,0,0",
                  busy, done, wr_cnt - w0, total_bits);
      end
   endtask

   task automatic test_reset_mid();
      int  d0 = done_cnt;
      wr_t e, o;
      launch(32'h0, 32'h140, 5);
      repeat (23) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_vec++;
      if ({busy, done, mem_we} !== 3'b000 || mem_a !== 32'h0 || mem_wd !== 32'h0 || total_bits !== '0) begin
         n_err++;
         $display("FAIL rstmid_outputs busy=%b done=%b we=%b a=%h tot=%0d want all 0",
                  busy, done, mem_we, mem_a, total_bits);
      end
      repeat (3) @(negedge clk);
      n_vec++;
      if (obs_q.size() != 2 || done_cnt != d0) begin
         n_err++;
         $display("FAIL rstmid_writes got=%0d dones=%0d want=2 dones=0", obs_q.size(), done_cnt - d0);
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_vec++;
         if (o.addr !== e.addr || o.data !== e.data) begin
            n_err++;
            $display("FAIL rstmid_write got=%h:%h want=%h:%h", o.addr, o.data, e.addr, e.data);
         end
      end
      launch(32'h20, 32'h20, 1);
      wait_done(1, "rstmid_restart");
   endtask

   task automatic test_busy_ignore();
      mem[19]  = 32'hC000_0003;
      mem[128] = 32'hDEAD_BEEF;
      launch(32'h4C, 32'h180, 1);
      @(negedge clk);
      @(negedge clk);
      src_addr = 32'h0;
      dst_addr = 32'h200;
      len      = LEN_W'(3);
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      wait_done(1, "busyign");
      n_vec++;
      if (mem[96] !== 32'd4 || mem[128] !== 32'hDEAD_BEEF || total_bits !== 12'd4) begin
         n_err++;
         $display("FAIL busyign_result got=%0d m128=%h tot=%0d want=4 DEADBEEF 4",
                  mem[96], mem[128], total_bits);
      end
   endtask

   task automatic test_wrap();
      mem[255] = 32'h0000_000F;
      mem[0]   = 32'h0000_00FF;
      launch(32'hFFFF_FFFC, 32'h300, 2);
      @(negedge clk);
      n_vec++;
      if (mem_a !== 32'hFFFF_FFFC) begin
         n_err++;
         $display("FAIL wrap_read0 got=%h want=FFFFFFFC", mem_a);
      end
      repeat (PER_WORD) @(negedge clk);
      n_vec++;
      if (mem_a !== 32'h0 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL wrap_read1 got=%h busy=%b want=00000000 busy=1", mem_a, busy);
      end
      wait_done(2, "wrap");
      n_vec++;
      if (mem[192] !== 32'd4 || mem[193] !== 32'd8) begin
         n_err++;
         $display("FAIL wrap_result got=%0d,%0d want=4,8", mem[192], mem[193]);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] seen;
      @(negedge clk);
      len   = '0;
      start = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         seen[c] = done;
      end
      start = 1'b0;
      n_vec++;
      if (seen !== 4'b0101) begin
         n_err++;
         $display("FAIL held_start_done_pattern got=%b want=0101", seen);
      end
      @(negedge clk);
   endtask

   initial begin
      for (int a = 0; a < DEPTH; a++) mem[a] = 32'h0;
      test_reset();
      test_basic();
      test_dense();
      test_inplace();
      test_len_zero();
      test_reset_mid();
      test_busy_ignore();
      test_wrap();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
